alu_mc: RTL and testbench

- Parametrised, handshaked successor to the single-cycle execute ALU.
- Accepts one operation at a time through a valid/ready input port and returns a registered result through a valid/ready output port.
- Simple ops and MUL complete in 1 cycle; DIV/DIVU/REM/REMU run on an iterative radix-2 divider.
- Division follows RISC-V semantics. The execute stage stalls on in_ready/out_valid.

---
 rtl/alu_mc_pkg.sv | 35 +++
 rtl/alu_div_serial.sv | 63 ++++++
 rtl/alu_mc.sv | 147 ++++++++++++++
 tb/tb_alu_mc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings, FSM states and small decode helpers for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD     = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 5'd1;
  localparam logic [OP_W-1:0] OP_AND     = 5'd2;
  localparam logic [OP_W-1:0] OP_OR      = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR     = 5'd4;
  localparam logic [OP_W-1:0] OP_LSHIFT  = 5'd5;
  localparam logic [OP_W-1:0] OP_LRSHIFT = 5'd6;
  localparam logic [OP_W-1:0] OP_ARSHIFT = 5'd7;
  localparam logic [OP_W-1:0] OP_SUBU    = 5'd8;
  localparam logic [OP_W-1:0] OP_MUL     = 5'd9;
  localparam logic [OP_W-1:0] OP_DIV     = 5'd10;
  localparam logic [OP_W-1:0] OP_DIVU    = 5'd11;
  localparam logic [OP_W-1:0] OP_REM     = 5'd12;
  localparam logic [OP_W-1:0] OP_REMU    = 5'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_rem_op(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_serial.sv
// Radix-2 restoring divider on operand magnitudes; one quotient bit per cycle, sign fixup on the last step.
module alu_div_serial #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] q, r, d;
  logic            neg_q, neg_r;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] q_nx, r_nx;

  // One restoring step; done/quot/rem present the final step combinationally so the caller can latch it
  always_comb begin
    rem_sh = {r, q[XLEN-1]};
    diff   = rem_sh - {1'b0, d};
    ge     = ~diff[XLEN];
    r_nx   = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    q_nx   = {q[XLEN-2:0], ge};
    done   = busy && (cnt == '0);
    quot   = neg_q ? -q_nx : q_nx;
    rem    = neg_r ? -r_nx : r_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(XLEN - 1);
      q     <= (is_signed && a[XLEN-1]) ? -a : a;
      d     <= (is_signed && b[XLEN-1]) ? -b : b;
      r     <= '0;
      neg_q <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r <= is_signed && a[XLEN-1];
    end else if (busy) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt - CW'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle simple ops and MUL, iterative divide, registered result and flags.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            div_by_zero,
  output logic            illegal_op
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            rem_sel;
  logic            accept;
  logic            go_div;
  logic [XLEN-1:0] imm_res;
  logic            imm_dbz, imm_ill;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [SHW-1:0]  sh;
  logic            b_zero, ovf;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_quot, div_rem, div_res;

  always_comb begin
    in_ready = ((state == IDLE) && !div_busy) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
    div_res  = rem_sel ? div_rem : div_quot;
  end

  // Single-cycle results and division special cases, decoded straight from the input port
  always_comb begin
    imm_res = '0;
    imm_dbz = 1'b0;
    imm_ill = 1'b0;
    go_div  = 1'b0;
    sh      = b[SHW-1:0];
    abs_a   = a[XLEN-1] ? -a : a;
    abs_b   = b[XLEN-1] ? -b : b;
    b_zero  = (b == '0);
    ovf     = (a == MIN_VAL) && (b == '1);
    case (alu_op)
      OP_ADD:     imm_res = a + b;
      OP_SUB:     imm_res = a - b;
      OP_AND:     imm_res = a & b;
      OP_OR:      imm_res = a | b;
      OP_XOR:     imm_res = a ^ b;
      OP_LSHIFT:  imm_res = a << sh;
      OP_LRSHIFT: imm_res = a >> sh;
      OP_ARSHIFT: imm_res = $unsigned($signed(a) >>> sh);
      OP_SUBU:    imm_res = abs_a - abs_b;
      OP_MUL:     imm_res = a * b;
      OP_DIV, OP_DIVU: begin
        if (b_zero) begin
          imm_res = '1;
          imm_dbz = 1'b1;
        end else if ((alu_op == OP_DIV) && ovf) begin
          imm_res = MIN_VAL;
        end else begin
          go_div = 1'b1;
        end
      end
      OP_REM, OP_REMU: begin
        if (b_zero) begin
          imm_res = a;
          imm_dbz = 1'b1;
        end else if ((alu_op == OP_REM) && ovf) begin
          imm_res = '0;
        end else begin
          go_div = 1'b1;
        end
      end
      default:    imm_ill = 1'b1;
    endcase
  end

  alu_div_serial #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && go_div),
    .is_signed (is_signed_div_op(alu_op)),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      rem_sel     <= 1'b0;
    end else begin
      case (state)
        DIV: begin
          if (div_done) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= div_res;
            zero        <= (div_res == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE share the issue path so a new op can follow a consumed result without a bubble
          if (accept) begin
            if (go_div) begin
              state     <= DIV;
              out_valid <= 1'b0;
              rem_sel   <= is_rem_op(alu_op);
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= imm_res;
              zero        <= (imm_res == '0);
              div_by_zero <= imm_dbz;
              illegal_op  <= imm_ill;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed ops push expectations, a negedge monitor pops on each consumed result.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] a, b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero, div_by_zero, illegal_op;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        dbz;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge after a negedge that sees out_valid && out_ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected no result", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("zero", 32'(zero), 32'(e.z));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          chk("illegal_op", 32'(illegal_op), 32'(e.ill));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] er, input logic ez, input logic ed, input logic ei,
                      input bit push);
    int n;
    in_valid = 1'b1;
    alu_op   = op;
    a        = av;
    b        = bv;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else if (push) begin
      sb.push_back('{res: er, z: ez, dbz: ed, ill: ei});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge to out_valid; ends at posedge+1 after the result is taken
  task automatic wait_lat(input int exp_lat);
    int n;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      if (exp_lat > 1) chk("in_ready_busy", 32'(in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("in_ready_done", 32'(in_ready), 32'(out_ready));
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input logic ez, input logic ed, input logic ei,
                     input int lat);
    send(op, av, bv, er, ez, ed, ei, 1'b1);
    wait_lat(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_op    = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ill", 32'(illegal_op), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op1(OP_ADD,     32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_ARSHIFT, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_LRSHIFT, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_SUB,     32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    op1(OP_SUBU,    32'hFFFFFFFB, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_AND,     32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_OR,      32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_LSHIFT,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0, 1);
    op1(OP_DIV,     32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 33);
    op1(OP_REM,     32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
    op1(OP_DIV,     32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 33);
    op1(OP_REM,     32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0, 33);
    op1(OP_DIVU,    32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33);
    op1(OP_REMU,    32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 33);
    op1(OP_DIVU,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1);
    op1(OP_REMU,    32'd5,        32'd0,        32'd5,        1'b0, 1'b1, 1'b0, 1);
    op1(OP_REM,     32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    op1(OP_DIV,     32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);

    // Back-pressure: MUL result must hold, then XOR issues in the same cycle the MUL is taken
    out_ready = 1'b0;
    send(OP_MUL, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_result", result, 32'hFFFFFFF4);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_lat(1);

    // Reset mid-division aborts it with no result
    send(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    op1(5'h1F, 32'd123, 32'd456, 32'd0, 1'b1, 1'b0, 1'b1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
